// File: rtl/pipelined_decode_stage_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU class encodings, immediate
// formats and the per-instruction control bundle produced by the decoder.
package pipelined_decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS   = 2'b11;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } immFmt_e;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic       illegal;
    logic [1:0] aluOp;
    logic       usesRs2;
    immFmt_e    immFmt;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_NONE = '{branch: 1'b0, jump: 1'b0, memRead: 1'b0,
                                        memToReg: 1'b0, memWrite: 1'b0, aluSrc: 1'b0,
                                        regWrite: 1'b0, illegal: 1'b0, aluOp: ALU_ADD,
                                        usesRs2: 1'b0, immFmt: IMM_R};

  // 32-bit sign-extended immediate; R-type (and anything unknown) yields zero.
  function automatic logic [31:0] immGen(input logic [31:0] instr, input immFmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one synchronous write,
// x0 hard-wired to zero and same-cycle write-through to both read ports.
module regfile_2r1w
  import pipelined_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_r [NUM_REGS];
  logic            wrEn_s;

  assign wrEn_s = we & (waddr != '0);

  function automatic logic [XLEN-1:0] readPort(input logic [RW-1:0] addr);
    logic [XLEN-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (wrEn_s && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = regs_r[addr];
    end
    return val;
  endfunction

  // Register array storage; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wrEn_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read ports with x0 forcing and write-through bypass.
  always_comb begin
    rdata1 = readPort(raddr1);
    rdata2 = readPort(raddr2);
  end

endmodule

// File: rtl/pipelined_decode_stage.sv
// In-order RV32 decode stage: operand read, control/immediate decode,
// load-use interlock and the ID/EX pipeline register.
module pipelined_decode_stage
  import pipelined_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RW-1:0]   ex_rs1,
  output logic [RW-1:0]   ex_rs2,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_illegal,
  output logic [1:0]      ex_alu_op
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            branch;
    logic            jump;
    logic            memRead;
    logic            memToReg;
    logic            memWrite;
    logic            aluSrc;
    logic            regWrite;
    logic            illegal;
    logic [1:0]      aluOp;
  } idex_t;

  logic [RW-1:0]   rs1Idx_s, rs2Idx_s, rdIdx_s;
  logic [XLEN-1:0] rs1Val_s, rs2Val_s, immExt_s;
  ctrlBundle_t     ctrl_s;
  logic            hazard_s, advance_s;
  idex_t           entry_s, idexNext_s, idex_r;

  assign rs1Idx_s = if_instr[15 +: RW];
  assign rs2Idx_s = if_instr[20 +: RW];
  assign rdIdx_s  = if_instr[7 +: RW];

  regfile_2r1w #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1Idx_s),
    .raddr2 (rs2Idx_s),
    .rdata1 (rs1Val_s),
    .rdata2 (rs2Val_s),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // Opcode to control bundle; unknown opcodes only raise the illegal flag.
  always_comb begin
    ctrl_s = CTRL_NONE;
    case (if_instr[6:0])
      OPC_OP:     begin ctrl_s.regWrite = 1'b1; ctrl_s.aluOp = ALU_FUNCT; ctrl_s.usesRs2 = 1'b1; end
      OPC_OP_IMM: begin ctrl_s.regWrite = 1'b1; ctrl_s.aluSrc = 1'b1; ctrl_s.aluOp = ALU_FUNCT; ctrl_s.immFmt = IMM_I; end
      OPC_LOAD:   begin ctrl_s.memRead = 1'b1; ctrl_s.memToReg = 1'b1; ctrl_s.regWrite = 1'b1;
                        ctrl_s.aluSrc = 1'b1; ctrl_s.immFmt = IMM_I; end
      OPC_STORE:  begin ctrl_s.memWrite = 1'b1; ctrl_s.aluSrc = 1'b1; ctrl_s.usesRs2 = 1'b1; ctrl_s.immFmt = IMM_S; end
      OPC_BRANCH: begin ctrl_s.branch = 1'b1; ctrl_s.aluOp = ALU_BRANCH; ctrl_s.usesRs2 = 1'b1; ctrl_s.immFmt = IMM_B; end
      OPC_JAL:    begin ctrl_s.jump = 1'b1; ctrl_s.regWrite = 1'b1; ctrl_s.immFmt = IMM_J; end
      OPC_JALR:   begin ctrl_s.jump = 1'b1; ctrl_s.regWrite = 1'b1; ctrl_s.aluSrc = 1'b1; ctrl_s.immFmt = IMM_I; end
      OPC_LUI:    begin ctrl_s.regWrite = 1'b1; ctrl_s.aluSrc = 1'b1; ctrl_s.aluOp = ALU_PASS; ctrl_s.immFmt = IMM_U; end
      OPC_AUIPC:  begin ctrl_s.regWrite = 1'b1; ctrl_s.aluSrc = 1'b1; ctrl_s.immFmt = IMM_U; end
      default:    begin ctrl_s.illegal = 1'b1; end
    endcase
  end

  assign immExt_s = XLEN'(signed'(immGen(if_instr, ctrl_s.immFmt)));

  // rs1 is always checked conservatively; rs2 only where the format reads it.
  assign hazard_s  = if_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                     ((ex_rd == rs1Idx_s) | (ctrl_s.usesRs2 & (ex_rd == rs2Idx_s)));
  assign advance_s = ex_ready | ~ex_valid;
  assign id_ready  = flush | (advance_s & ~hazard_s);

  // Assemble the ID/EX entry for the instruction currently presented.
  always_comb begin
    entry_s          = '0;
    entry_s.valid    = 1'b1;
    entry_s.pc       = if_pc;
    entry_s.rs1Val   = rs1Val_s;
    entry_s.rs2Val   = rs2Val_s;
    entry_s.imm      = immExt_s;
    entry_s.rs1      = rs1Idx_s;
    entry_s.rs2      = rs2Idx_s;
    entry_s.rd       = rdIdx_s;
    entry_s.branch   = ctrl_s.branch;
    entry_s.jump     = ctrl_s.jump;
    entry_s.memRead  = ctrl_s.memRead;
    entry_s.memToReg = ctrl_s.memToReg;
    entry_s.memWrite = ctrl_s.memWrite;
    entry_s.aluSrc   = ctrl_s.aluSrc;
    entry_s.regWrite = ctrl_s.regWrite;
    entry_s.illegal  = ctrl_s.illegal;
    entry_s.aluOp    = ctrl_s.aluOp;
  end

  // Next ID/EX contents: flush kills, advance loads entry or bubble, else hold.
  always_comb begin
    idexNext_s = idex_r;
    if (flush) begin
      idexNext_s = '0;
    end else if (advance_s) begin
      if (if_valid && !hazard_s) begin
        idexNext_s = entry_s;
      end else begin
        idexNext_s = '0;
      end
    end else begin
      idexNext_s = idex_r;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_r <= '0;
    end else begin
      idex_r <= idexNext_s;
    end
  end

  assign ex_valid      = idex_r.valid;
  assign ex_pc         = idex_r.pc;
  assign ex_rs1_val    = idex_r.rs1Val;
  assign ex_rs2_val    = idex_r.rs2Val;
  assign ex_imm        = idex_r.imm;
  assign ex_rs1        = idex_r.rs1;
  assign ex_rs2        = idex_r.rs2;
  assign ex_rd         = idex_r.rd;
  assign ex_branch     = idex_r.branch;
  assign ex_jump       = idex_r.jump;
  assign ex_mem_read   = idex_r.memRead;
  assign ex_mem_to_reg = idex_r.memToReg;
  assign ex_mem_write  = idex_r.memWrite;
  assign ex_alu_src    = idex_r.aluSrc;
  assign ex_reg_write  = idex_r.regWrite;
  assign ex_illegal    = idex_r.illegal;
  assign ex_alu_op     = idex_r.aluOp;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Scoreboard bench for pipelined_decode_stage: expected ID/EX entries are
// queued on acceptance and compared while they sit on the ex_* outputs.
module tb_pipelined_decode_stage;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [6:0] OPCS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                       7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        branch;
    logic        jump;
    logic        memRead;
    logic        memToReg;
    logic        memWrite;
    logic        aluSrc;
    logic        regWrite;
    logic        illegal;
    logic [1:0]  aluOp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_valid, id_ready, wb_we, flush, ex_ready, ex_valid;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0] wb_rd;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic ex_alu_src, ex_reg_write, ex_illegal;
  logic [1:0] ex_alu_op;

  int checks = 0;
  int fails = 0;
  logic [31:0] mdlRegs [NREG];
  exp_t sb[$];

  always #5 clk = ~clk;

  pipelined_decode_stage #(.XLEN(XLEN), .NUM_REGS(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op)
  );

  function automatic logic [31:0] encR(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] encI(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                       logic [11:0] imm, logic [2:0] f3);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encB(logic [4:0] rs1, logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rdModel(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return mdlRegs[idx];
  endfunction

  // Reference decode of one instruction into the entry expected on ex_*.
  function automatic exp_t model(logic [31:0] i, logic [31:0] pc);
    exp_t e;
    logic [6:0] op;
    e = '0;
    op = i[6:0];
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.rs1v = rdModel(i[19:15]); e.rs2v = rdModel(i[24:20]);
    if (op == 7'h33) begin
      e.regWrite = 1'b1; e.aluOp = 2'b10;
    end else if (op == 7'h13) begin
      e.regWrite = 1'b1; e.aluSrc = 1'b1; e.aluOp = 2'b10; e.imm = {{20{i[31]}}, i[31:20]};
    end else if (op == 7'h03) begin
      e.memRead = 1'b1; e.memToReg = 1'b1; e.regWrite = 1'b1; e.aluSrc = 1'b1;
      e.imm = {{20{i[31]}}, i[31:20]};
    end else if (op == 7'h23) begin
      e.memWrite = 1'b1; e.aluSrc = 1'b1; e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
    end else if (op == 7'h63) begin
      e.branch = 1'b1; e.aluOp = 2'b01;
      e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    end else if (op == 7'h6F) begin
      e.jump = 1'b1; e.regWrite = 1'b1;
      e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end else if (op == 7'h67) begin
      e.jump = 1'b1; e.regWrite = 1'b1; e.aluSrc = 1'b1; e.imm = {{20{i[31]}}, i[31:20]};
    end else if (op == 7'h37) begin
      e.regWrite = 1'b1; e.aluSrc = 1'b1; e.aluOp = 2'b11; e.imm = {i[31:12], 12'h000};
    end else if (op == 7'h17) begin
      e.regWrite = 1'b1; e.aluSrc = 1'b1; e.imm = {i[31:12], 12'h000};
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Expected id_ready from the bench's own view of what sits in EX.
  function automatic bit expIdReady();
    bit haz;
    bit exV;
    logic [6:0] op;
    exV = (sb.size() != 0);
    op = if_instr[6:0];
    haz = 1'b0;
    if (if_valid && exV && sb[0].memRead && sb[0].rd != 5'd0) begin
      if (sb[0].rd == if_instr[19:15]) haz = 1'b1;
      if ((op == 7'h33 || op == 7'h23 || op == 7'h63) && sb[0].rd == if_instr[24:20]) haz = 1'b1;
    end
    if (flush) return 1'b1;
    return (ex_ready || !exV) && !haz;
  endfunction

  function automatic exp_t snap();
    exp_t s;
    s.pc = ex_pc; s.rs1v = ex_rs1_val; s.rs2v = ex_rs2_val; s.imm = ex_imm;
    s.rs1 = ex_rs1; s.rs2 = ex_rs2; s.rd = ex_rd;
    s.branch = ex_branch; s.jump = ex_jump; s.memRead = ex_mem_read;
    s.memToReg = ex_mem_to_reg; s.memWrite = ex_mem_write; s.aluSrc = ex_alu_src;
    s.regWrite = ex_reg_write; s.illegal = ex_illegal; s.aluOp = ex_alu_op;
    return s;
  endfunction

  function automatic exp_t sbHead();
    if (sb.size() == 0) return '0;
    return sb[0];
  endfunction

  // One rising edge: update the scoreboard and shadow registers; returns at edge+1.
  task automatic step();
    exp_t e;
    bit acc;
    bit cons;
    #1;
    acc = if_valid && expIdReady() && !flush;
    cons = (sb.size() != 0) && ex_ready;
    e = model(if_instr, if_pc);
    @(posedge clk);
    if (flush) sb.delete();
    else if (cons) void'(sb.pop_front());
    if (acc) sb.push_back(e);
    if (wb_we && wb_rd != 5'd0) mdlRegs[wb_rd] = wb_data;
    #1;
  endtask

  task automatic test_reset();
    if_valid = 1'b0; if_instr = 32'h0000_0013; if_pc = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
    for (int i = 0; i < NREG; i++) mdlRegs[i] = 32'd0;
    sb.delete();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++;
    if (snap() !== exp_t'('0)) begin fails++; $display("FAIL reset_outputs: got %h expected 0", snap()); end
    checks++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", id_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_idle: got %b expected 0", ex_valid); end
  endtask

  task automatic test_bypass();
    ex_ready = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    if_valid = 1'b1; if_instr = encR(5'd1, 5'd5, 5'd0); if_pc = 32'h100;
    step();
    wb_we = 1'b0; if_instr = encR(5'd2, 5'd5, 5'd5); if_pc = 32'h104;
    checks++;
    if (ex_rs1_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_rs1: got %h expected deadbeef", ex_rs1_val); end
    checks++;
    if (ex_valid !== 1'b1 || snap() !== sbHead()) begin
      fails++; $display("FAIL bypass_entry: valid %b got %h expected %h", ex_valid, snap(), sbHead());
    end
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_rs2_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL regfile_read: got %h expected deadbeef", ex_rs2_val); end
    checks++;
    if (ex_valid !== 1'b1 || snap() !== sbHead()) begin
      fails++; $display("FAIL regfile_entry: valid %b got %h expected %h", ex_valid, snap(), sbHead());
    end
    step();
  endtask

  task automatic test_load_use();
    ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = encI(7'h03, 5'd3, 5'd2, 12'd0, 3'b010); if_pc = 32'h200;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || snap() !== sbHead()) begin
      fails++; $display("FAIL lw_entry: valid %b got %h expected %h", ex_valid, snap(), sbHead());
    end
    if_instr = encR(5'd4, 5'd3, 5'd1); if_pc = 32'h204;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL hazard_ready: got %b expected 0", id_ready); end
    step();
    checks++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL hazard_bubble: got %b expected 0", ex_valid); end
    #1;
    checks++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL hazard_release: got %b expected 1", id_ready); end
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || snap() !== sbHead()) begin
      fails++; $display("FAIL add_after_load: valid %b got %h expected %h", ex_valid, snap(), sbHead());
    end
    step();
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = encI(7'h13, 5'd6, 5'd1, 12'd5, 3'b000); if_pc = 32'h300;
    step();
    ex_ready = 1'b0;
    if_instr = encI(7'h13, 5'd7, 5'd0, 12'd7, 3'b000); if_pc = 32'h304;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", c, id_ready); end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || snap() !== sbHead()) begin
        fails++; $display("FAIL stall_hold[%0d]: got %h expected %h", c, snap(), sbHead());
      end
    end
    ex_ready = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b expected 1", id_ready); end
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h304 || snap() !== sbHead()) begin
      fails++; $display("FAIL stall_next: got %h expected %h", snap(), sbHead());
    end
    step();
  endtask

  task automatic test_flush_stall();
    ex_ready = 1'b1; if_valid = 1'b1;
    if_instr = encI(7'h03, 5'd8, 5'd0, 12'd0, 3'b010); if_pc = 32'h380;
    step();
    if_instr = encR(5'd9, 5'd8, 5'd8); if_pc = 32'h384;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL flush_prestall: got %b expected 0", id_ready); end
    flush = 1'b1; ex_ready = 1'b0;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b expected 1", id_ready); end
    step();
    checks++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_kill: got %b expected 0", ex_valid); end
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    step();
    checks++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_after: got %b expected 0", ex_valid); end
  endtask

  task automatic test_x0_imm_illegal();
    ex_ready = 1'b1; if_valid = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    if_instr = encR(5'd10, 5'd0, 5'd0); if_pc = 32'h400;
    step();
    wb_we = 1'b0;
    if_instr = encI(7'h13, 5'd11, 5'd0, 12'd0, 3'b000); if_pc = 32'h404;
    checks++;
    if (ex_rs1_val !== 32'd0) begin fails++; $display("FAIL x0_bypass: got %h expected 0", ex_rs1_val); end
    step();
    if_instr = encB(5'd1, 5'd2, 13'h1FFC); if_pc = 32'h408;
    checks++;
    if (ex_rs1_val !== 32'd0 || snap() !== sbHead()) begin
      fails++; $display("FAIL x0_read: got %h expected %h", snap(), sbHead());
    end
    step();
    if_instr = 32'h0000_0FFF; if_pc = 32'h40C;
    checks++;
    if (ex_imm !== 32'hFFFF_FFFC || ex_branch !== 1'b1) begin
      fails++; $display("FAIL beq_imm: got %h branch %b expected fffffffc branch 1", ex_imm, ex_branch);
    end
    checks++;
    if (snap() !== sbHead()) begin fails++; $display("FAIL beq_entry: got %h expected %h", snap(), sbHead()); end
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0
        || ex_mem_read !== 1'b0 || ex_branch !== 1'b0 || ex_jump !== 1'b0) begin
      fails++; $display("FAIL illegal_ctrl: got %h expected illegal only", snap());
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom();
      r[6:0] = OPCS[$urandom_range(0, 9)];
      r[19:18] = 2'b00; r[24:23] = 2'b00; r[11:10] = 2'b00;
      if_instr = r;
      if_pc = $urandom();
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_we = ($urandom_range(0, 1) != 0);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom();
      flush = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (id_ready !== expIdReady()) begin
        fails++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, id_ready, expIdReady());
      end
      step();
      checks++;
      if (ex_valid !== (sb.size() != 0) || (ex_valid === 1'b1 && snap() !== sbHead())) begin
        fails++; $display("FAIL rand_entry[%0d]: valid %b got %h expected %h", n, ex_valid, snap(), sbHead());
      end
    end
    flush = 1'b0; wb_we = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midflight();
    ex_ready = 1'b0; if_valid = 1'b1;
    if_instr = encI(7'h03, 5'd12, 5'd0, 12'd0, 3'b010); if_pc = 32'h500;
    step();
    if_instr = encR(5'd13, 5'd12, 5'd0); if_pc = 32'h504;
    #1;
    checks++;
    if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
      fails++; $display("FAIL midflight_stall: ready %b valid %b expected 0 1", id_ready, ex_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || snap() !== exp_t'('0)) begin
      fails++; $display("FAIL async_reset: valid %b got %h expected 0", ex_valid, snap());
    end
    sb.delete();
    for (int i = 0; i < NREG; i++) mdlRegs[i] = 32'd0;
    #1 rst_n = 1'b1;
    ex_ready = 1'b1; wb_we = 1'b0;
    if_instr = encR(5'd1, 5'd5, 5'd6); if_pc = 32'h600;
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_val !== 32'd0 || ex_pc !== 32'h600 || snap() !== sbHead()) begin
      fails++; $display("FAIL post_reset_accept: valid %b got %h expected %h", ex_valid, snap(), sbHead());
    end
    step();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush_stall();
    test_x0_imm_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_decode_stage.md
PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register values, PC and immediates.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; index width RW = clog2(NUM_REGS).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_valid  in  1  fetch presents an instruction.
REQ-006 if_instr  in  32  RV32 instruction word.
REQ-007 if_pc  in  XLEN  PC of if_instr.
REQ-008 id_ready  out  1  decode accepts if_instr this cycle.
REQ-009 wb_we  in  1  write-back enable.
REQ-010 wb_rd  in  RW  write-back register index.
REQ-011 wb_data  in  XLEN  write-back data.
REQ-012 flush  in  1  branch/jump redirect; kill decode and ID/EX contents.
REQ-013 ex_ready  in  1  execute stage accepts the ID/EX entry.
REQ-014 ex_valid  out  1  ID/EX entry valid.
REQ-015 ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  registered PC, operands, sign-extended immediate.
REQ-016 ex_rs1, ex_rs2, ex_rd  out  RW each  registered register indices.
REQ-017 ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_illegal  out  1 each  registered control.
REQ-018 ex_alu_op  out  2  registered ALU class: 00 add, 01 branch-compare, 10 R/I funct-decoded, 11 pass-immediate (LUI).

Function
REQ-019 Register file: NUM_REGS x XLEN, two combinational reads (instr[19:15], instr[24:20]), one synchronous write when wb_we and wb_rd != 0.
REQ-020 Register 0 SHALL always read 0; writes to it are discarded.
REQ-021 Write-through bypass: read index equal to wb_rd with wb_we=1 and wb_rd!=0 SHALL return wb_data in the same cycle.
REQ-022 Decode opcodes OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; any other opcode sets ex_illegal=1 with all write/memory/branch controls 0.
REQ-023 Immediate formats I, S, B, U, J, sign-extended to XLEN; R-type immediate 0.
REQ-024 Load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 or ex_rd==rs2 of if_instr) with if_valid=1; rs2 compared only for R, STORE, BRANCH.
REQ-025 id_ready = (ex_ready | ~ex_valid) & ~hazard, or 1 when flush=1.
REQ-026 ID/EX advance when (ex_ready | ~ex_valid): loads decoded if_instr with ex_valid=1 if if_valid & ~hazard & ~flush; otherwise loads bubble (ex_valid=0, all controls 0).
REQ-027 No advance: ID/EX holds all outputs unchanged.
REQ-028 flush=1 SHALL set ex_valid=0 next cycle regardless of ex_ready, stall or if_valid; flush has priority over hazard and hold.
REQ-029 Latency: accepted instruction appears on ex_* exactly one cycle after acceptance edge.
REQ-030 Hazard stalls exactly one cycle when ex_ready=1 (bubble inserted, load leaves EX).
REQ-031 Bypass applies to same-cycle wb write; hazard logic and bypass are independent.

Reset
REQ-032 rst_n low SHALL immediately set ex_valid=0, all ex_* outputs 0, all registers 0.
REQ-033 Reset mid-stall or mid-flush discards the in-flight entry; first edge after release with if_valid=1 accepts a new instruction.

Structure
REQ-034 Shared package: opcode constants, ex_alu_op encodings, immediate-format enum, control-bundle struct.
REQ-035 One sub-module regfile_2r1w (parametrised XLEN, NUM_REGS, with bypass); decode, immediate generation, hazard and ID/EX register in the top.

Verification
REQ-036 wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, same cycle decode ADD x1,x5,x0 -> next cycle ex_rs1_val=0xDEADBEEF.
REQ-037 LW x3,0(x2) accepted, then ADD x4,x3,x1 with ex_ready=1 -> id_ready=0 one cycle, bubble ex_valid=0, ADD on ex_* the cycle after.
REQ-038 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0; release -> next instruction loads.
REQ-039 flush=1 during a load-use stall -> ex_valid=0 next cycle, id_ready=1 that cycle.
REQ-040 Write x0=0x1234 then read x0 -> 0; BEQ imm -4 -> ex_imm=0xFFFFFFFC; opcode 0x7F -> ex_illegal=1, ex_reg_write=0.
REQ-041 rst_n asserted while ex_valid=1 -> ex_valid=0 without clock edge; registers read 0 after release.
